// File: rtl/gat_layer_scheduler.sv
// Multi-layer GAT sequencer around gat_top: waits for host loads, runs each layer, then drains the new-feature BRAM into a valid/ready stream.
// Optional watchdog (err_timeout port, TIMEOUT_W parameter) is enabled by defining GAT_SCHED_WATCHDOG_EN.
module gat_layer_scheduler #(
    parameter int NUM_LAYERS         = 2,
    parameter int NEW_FEATURE_DEPTH  = 43328,
    parameter int NEW_FEATURE_ADDR_W = 16,
    parameter int NEW_FEATURE_WIDTH  = 32,
`ifdef GAT_SCHED_WATCHDOG_EN
    parameter int TIMEOUT_W          = 24,
`endif
    parameter int RD_LATENCY         = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          h_data_bram_load_done,
    input  logic                          h_node_info_bram_load_done,
    input  logic                          wgt_bram_load_done,
    output logic                          wgt_reload_req,
    output logic                          gat_layer,
    output logic                          gat_run,
    input  logic                          gat_ready,
    output logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]  out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
`ifdef GAT_SCHED_WATCHDOG_EN
    output logic                          err_timeout,
`endif
    output logic                          busy,
    output logic                          done,
    output logic [7:0]                    layer_idx
);

    localparam int FIFO_DEPTH = RD_LATENCY + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W      = NEW_FEATURE_ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_LOAD, S_RUN, S_ARM, S_WAIT_DONE, S_WAIT_WGT_LOW, S_WAIT_WGT_HIGH, S_DRAIN
    } state_e;

    state_e                        state_q, state_d;
    logic [7:0]                    layer_q, layer_d;
    logic [NEW_FEATURE_ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]              issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0]              out_cnt_q, out_cnt_d;
    logic [RD_LATENCY:0]           rd_vld_q, rd_vld_d;
    logic [CNT_W-1:0]              fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NEW_FEATURE_WIDTH-1:0]  mem [FIFO_DEPTH];

    logic             push, pop, last_word, drain_active, issue;
    logic [CNT_W-1:0] inflight;

    assign push      = rd_vld_q[RD_LATENCY];
    assign out_valid = (fifo_cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign last_word = (out_cnt_q == IDX_W'(NEW_FEATURE_DEPTH - 1));

`ifdef GAT_SCHED_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 err_q, err_d, timeout;

    always_comb begin
        timeout = (&wd_q) && (state_q inside {S_ARM, S_WAIT_DONE, S_WAIT_WGT_LOW, S_WAIT_WGT_HIGH});
        err_d   = err_q | timeout;
        wd_d    = (state_d != state_q) ? '0 : ((&wd_q) ? wd_q : wd_q + TIMEOUT_W'(1));
    end

    assign err_timeout = err_q;
`endif

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d        = state_q;
        layer_d        = layer_q;
        gat_run        = 1'b0;
        wgt_reload_req = 1'b0;
        done           = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_WAIT_LOAD;
                layer_d = '0;
            end
            S_WAIT_LOAD: if (h_data_bram_load_done && h_node_info_bram_load_done && wgt_bram_load_done)
                state_d = S_RUN;
            S_RUN: begin
                gat_run = 1'b1;
                state_d = S_ARM;
            end
            S_ARM: if (!gat_ready) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (gat_ready) begin
                if (layer_q == 8'(NUM_LAYERS - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    wgt_reload_req = 1'b1;
                    state_d        = S_WAIT_WGT_LOW;
                end
            end
            S_WAIT_WGT_LOW: if (!wgt_bram_load_done) state_d = S_WAIT_WGT_HIGH;
            S_WAIT_WGT_HIGH: if (wgt_bram_load_done) begin
                layer_d = layer_q + 8'd1;
                state_d = S_RUN;
            end
            S_DRAIN: if (pop && last_word) begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef GAT_SCHED_WATCHDOG_EN
        if (timeout) begin
            state_d        = S_IDLE;
            layer_d        = layer_q;
            wgt_reload_req = 1'b0;
        end
`endif
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= RD_LATENCY; i++) inflight = inflight + CNT_W'(rd_vld_q[i]);

        // Address 0 goes out on the transition into DRAIN; a word popped this cycle frees its slot now.
        drain_active = (state_q == S_DRAIN) || (state_q == S_WAIT_DONE && state_d == S_DRAIN);
        issue = drain_active && (issue_cnt_q < IDX_W'(NEW_FEATURE_DEPTH)) &&
                ((int'(fifo_cnt_q) + int'(inflight) - int'(pop)) < FIFO_DEPTH);

        addr_d      = issue ? issue_cnt_q[NEW_FEATURE_ADDR_W-1:0] : addr_q;
        issue_cnt_d = issue ? issue_cnt_q + IDX_W'(1) : issue_cnt_q;
        out_cnt_d   = pop ? out_cnt_q + IDX_W'(1) : out_cnt_q;
        if (state_q == S_IDLE) begin
            issue_cnt_d = '0;
            out_cnt_d   = '0;
        end

        rd_vld_d   = {rd_vld_q[RD_LATENCY-1:0], issue};
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            layer_q     <= '0;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            rd_vld_q    <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
`ifdef GAT_SCHED_WATCHDOG_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            rd_vld_q    <= rd_vld_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
`ifdef GAT_SCHED_WATCHDOG_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    // NOTE: FIFO storage is not reset; the cleared count/pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= feat_bram_dout;
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && fifo_cnt_q == CNT_W'(FIFO_DEPTH)));

    assign out_data        = out_valid ? mem[rd_ptr_q] : '0;
    assign out_last        = out_valid && last_word;
    assign feat_bram_addrb = addr_q;
    assign layer_idx       = layer_q;
    assign gat_layer       = (layer_q != 8'd0);
    assign busy            = (state_q != S_IDLE);

endmodule
